// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU issue arbiter.
// States, payload/result bundles and instruction type codes.
package alu_arb_pkg;

  localparam int DATA_W      = 32;
  localparam int TIMEOUT_DEF = 255;

  localparam logic [3:0] TYPE_DP   = 4'b0000;
  localparam logic [3:0] TYPE_BR   = 4'b0001;
  localparam logic [3:0] TYPE_LDST = 4'b0010;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_LO,
    WAIT_HI,
    CAPTURE
  } state_t;

  typedef struct packed {
    logic [3:0]        typ;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] d3;
    logic [DATA_W-1:0] d4;
    logic [DATA_W-1:0] srcdst;
  } payload_t;

  typedef struct packed {
    logic [DATA_W-1:0] res1;
    logic [DATA_W-1:0] res2;
    logic [DATA_W-1:0] cpsr;
    logic [DATA_W-1:0] srcdst;
    logic              w;
    logic              m;
  } result_t;

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// Issue-side bundle: per-requester request buses plus the tagged response.
// master = decoder issue logic, slave = arbiter.
interface alu_issue_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*4-1:0]      req_type;
  logic [NREQ*DATA_W-1:0] req_data1;
  logic [NREQ*DATA_W-1:0] req_data2;
  logic [NREQ*DATA_W-1:0] req_data3;
  logic [NREQ*DATA_W-1:0] req_data4;
  logic [NREQ*DATA_W-1:0] req_srcdst;

  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [DATA_W-1:0]      rsp_data1;
  logic [DATA_W-1:0]      rsp_data2;
  logic [DATA_W-1:0]      rsp_cpsr;
  logic [DATA_W-1:0]      rsp_srcdst;
  logic                   rsp_w;
  logic                   rsp_m;

  modport master (
    output req_valid, req_type,
    output req_data1, req_data2,
    output req_data3, req_data4,
    output req_srcdst,
    input  req_ready,
    input  rsp_valid, rsp_id,
    input  rsp_data1, rsp_data2,
    input  rsp_cpsr, rsp_srcdst,
    input  rsp_w, rsp_m
  );

  modport slave (
    input  req_valid, req_type,
    input  req_data1, req_data2,
    input  req_data3, req_data4,
    input  req_srcdst,
    output req_ready,
    output rsp_valid, rsp_id,
    output rsp_data1, rsp_data2,
    output rsp_cpsr, rsp_srcdst,
    output rsp_w, rsp_m
  );

endinterface

// File: rtl/alu_ready_sync.sv
// Multi-flop synchronizer bringing the async ALU readyOut into clk.
// Cleared on reset so the first operation sees a low ready.
module alu_ready_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic alu_ready_i,
  output logic rdy_s
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], alu_ready_i};
    end
  end

  assign rdy_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin front end sharing one asynchronous ALU among NREQ issue slots.
// Define ALU_ARB_TIMEOUT_EN to enable the sticky watchdog on the WAIT states.
module alu_issue_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  alu_issue_arbiter_if.slave issue,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [DATA_W-1:0] alu_data3,
  output logic [DATA_W-1:0] alu_data4,
  output logic [3:0]        alu_type,
  output logic [DATA_W-1:0] alu_srcdst,
  output logic              alu_trigger,
  output logic              alu_go,
  input  logic              alu_ready_i,
  input  logic [DATA_W-1:0] alu_res1,
  input  logic [DATA_W-1:0] alu_res2,
  input  logic [DATA_W-1:0] alu_cpsr,
  input  logic [DATA_W-1:0] alu_srcdst_i,
  input  logic              alu_w,
  input  logic              alu_m,
  output logic              busy,
  output logic              error
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t         state, state_n;
  logic           rdy_s;
  logic           first_op;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] hi_id, lo_id;
  logic           hi_hit, lo_hit;
  logic           launch;
  payload_t       pl_a [NREQ];
  payload_t       pl_q;
  result_t        rsp_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic           trig_q;
  logic           go_q;

  alu_ready_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .reset       (reset),
    .alu_ready_i (alu_ready_i),
    .rdy_s       (rdy_s)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      pl_a[i].typ    = issue.req_type[i*4 +: 4];
      pl_a[i].d1     = issue.req_data1[i*DATA_W +: DATA_W];
      pl_a[i].d2     = issue.req_data2[i*DATA_W +: DATA_W];
      pl_a[i].d3     = issue.req_data3[i*DATA_W +: DATA_W];
      pl_a[i].d4     = issue.req_data4[i*DATA_W +: DATA_W];
      pl_a[i].srcdst = issue.req_srcdst[i*DATA_W +: DATA_W];
    end
  end

  // Lowest valid index above ptr wins; otherwise wrap to lowest at/below ptr.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (issue.req_valid[i]) begin
        if (IDW'(i) > ptr) begin
          hi_hit = 1'b1;
          hi_id  = IDW'(i);
        end else begin
          lo_hit = 1'b1;
          lo_id  = IDW'(i);
        end
      end
    end
    grant_id = hi_hit ? hi_id : lo_id;
  end

  assign launch = (state == IDLE) && !reset
                  && (hi_hit || lo_hit)
                  && (rdy_s || first_op);

  assign issue.req_ready = launch ? (NREQ'(1) << grant_id)
                                  : '0;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIM = 16'(TIMEOUT - 2);

  logic [15:0] wd_cnt;
  logic        wd_hit;
  logic        err_q;

  assign wd_hit = ((state == WAIT_LO) || (state == WAIT_HI))
                  && (wd_cnt == WD_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == LAUNCH) begin
        wd_cnt <= '0;
      end else if ((state == WAIT_LO) || (state == WAIT_HI)) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
      if (wd_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (launch) state_n = LAUNCH;
      LAUNCH:  state_n = WAIT_LO;
      WAIT_LO: if (!rdy_s) state_n = WAIT_HI;
      WAIT_HI: if (rdy_s) state_n = CAPTURE;
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef ALU_ARB_TIMEOUT_EN
    if (wd_hit) begin
      state_n = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= IDW'(NREQ - 1);
      first_op    <= 1'b1;
      pl_q        <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      trig_q      <= 1'b0;
      go_q        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (launch) begin
        ptr  <= grant_id;
        pl_q <= pl_a[grant_id];
      end
      if (state == LAUNCH) begin
        trig_q <= ~trig_q;
        go_q   <= 1'b1;
      end
      if (state == CAPTURE) begin
        rsp_q.res1   <= alu_res1;
        rsp_q.res2   <= alu_res2;
        rsp_q.cpsr   <= alu_cpsr;
        rsp_q.srcdst <= alu_srcdst_i;
        rsp_q.w      <= alu_w;
        rsp_q.m      <= alu_m;
        rsp_valid_q  <= 1'b1;
        rsp_id_q     <= ptr;
        go_q         <= 1'b0;
        first_op     <= 1'b0;
      end
`ifdef ALU_ARB_TIMEOUT_EN
      // A hung ALU never raises ready again; re-arm as if fresh.
      if (wd_hit) begin
        go_q     <= 1'b0;
        first_op <= 1'b1;
      end
`endif
    end
  end

  assign alu_data1  = pl_q.d1;
  assign alu_data2  = pl_q.d2;
  assign alu_data3  = pl_q.d3;
  assign alu_data4  = pl_q.d4;
  assign alu_type   = pl_q.typ;
  assign alu_srcdst = pl_q.srcdst;
  assign alu_trigger = trig_q;
  assign alu_go      = go_q;

  assign issue.rsp_valid  = rsp_valid_q;
  assign issue.rsp_id     = rsp_id_q;
  assign issue.rsp_data1  = rsp_q.res1;
  assign issue.rsp_data2  = rsp_q.res2;
  assign issue.rsp_cpsr   = rsp_q.cpsr;
  assign issue.rsp_srcdst = rsp_q.srcdst;
  assign issue.rsp_w      = rsp_q.w;
  assign issue.rsp_m      = rsp_q.m;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a small async-ALU model.
// Watchdog vectors run only when ALU_ARB_TIMEOUT_EN is defined.
module tb_alu_issue_arbiter;
  import alu_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int SYNC = 2;
  localparam int LAT  = 3;
`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 255;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_issue_arbiter_if #(.NREQ(NREQ)) issue();

  logic [31:0] alu_data1, alu_data2;
  logic [31:0] alu_data3, alu_data4;
  logic [3:0]  alu_type;
  logic [31:0] alu_srcdst;
  logic        alu_trigger, alu_go;
  logic        busy, error;
  logic        alu_ready_i = 1'b0;
  logic [31:0] alu_res1 = '0;
  logic [31:0] alu_res2 = '0;
  logic [31:0] alu_cpsr = '0;
  logic [31:0] alu_srcdst_i = '0;
  logic        alu_w = 1'b0;
  logic        alu_m = 1'b0;

  alu_issue_arbiter #(
    .NREQ        (NREQ),
    .SYNC_STAGES (SYNC),
    .TIMEOUT     (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .issue        (issue),
    .alu_data1    (alu_data1),
    .alu_data2    (alu_data2),
    .alu_data3    (alu_data3),
    .alu_data4    (alu_data4),
    .alu_type     (alu_type),
    .alu_srcdst   (alu_srcdst),
    .alu_trigger  (alu_trigger),
    .alu_go       (alu_go),
    .alu_ready_i  (alu_ready_i),
    .alu_res1     (alu_res1),
    .alu_res2     (alu_res2),
    .alu_cpsr     (alu_cpsr),
    .alu_srcdst_i (alu_srcdst_i),
    .alu_w        (alu_w),
    .alu_m        (alu_m),
    .busy         (busy),
    .error        (error)
  );

  // ALU model: drops ready on a trigger edge, returns results LAT clks later.
  logic        alu_rst = 1'b1;
  logic        hang = 1'b0;
  logic        last_trig = 1'b0;
  logic        running = 1'b0;
  int          cnt = 0;
  logic [31:0] cpsr_cfg = '0;
  logic        w_cfg = 1'b0;
  logic        m_cfg = 1'b0;

  always @(negedge clk) begin
    if (alu_rst) begin
      alu_ready_i = 1'b0;
      running     = 1'b0;
      last_trig   = 1'b0;
    end else if (alu_go && (alu_trigger != last_trig)) begin
      last_trig   = alu_trigger;
      alu_ready_i = 1'b0;
      running     = 1'b1;
      cnt         = LAT;
    end else if (running && !hang) begin
      if (cnt <= 1) begin
        alu_res1     = alu_data1 + alu_data2;
        alu_res2     = alu_data1 - alu_data2;
        alu_cpsr     = cpsr_cfg;
        alu_w        = w_cfg;
        alu_m        = m_cfg;
        alu_srcdst_i = alu_srcdst;
        alu_ready_i  = 1'b1;
        running      = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
  end

  int   rsp_cnt = 0;
  int   tog_cnt = 0;
  logic trig_prev = 1'b0;

  always @(negedge clk) begin
    if (issue.rsp_valid) rsp_cnt = rsp_cnt + 1;
    if (alu_trigger !== trig_prev) tog_cnt = tog_cnt + 1;
    trig_prev = alu_trigger;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    issue.req_valid = '0;
    reset   = 1'b1;
    alu_rst = 1'b1;
    step();
    step();
    reset   = 1'b0;
    alu_rst = 1'b0;
  endtask

  task automatic set_req(input int r, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [3:0] t,
                         input logic [31:0] sd);
    issue.req_type[r*4 +: 4]     = t;
    issue.req_data1[r*32 +: 32]  = d1;
    issue.req_data2[r*32 +: 32]  = d2;
    issue.req_data3[r*32 +: 32]  = 32'h0;
    issue.req_data4[r*32 +: 32]  = 32'h0;
    issue.req_srcdst[r*32 +: 32] = sd;
  endtask

  // One isolated op on requester r; expects grant now and rsp 9 cycles later.
  task automatic do_op(input int r, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [3:0] t,
                       input logic [31:0] sd, input logic [31:0] exp1,
                       input string tag);
    int n;
    bit seen;
    step();
    set_req(r, d1, d2, t, sd);
    issue.req_valid[r] = 1'b1;
    #1;
    check({tag, "_grant"}, 32'(issue.req_ready), 32'(1) << r);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (n == 1) begin
        issue.req_valid[r] = 1'b0;
        issue.req_data1[r*32 +: 32] = 32'hdead_beef;
      end
      seen = issue.rsp_valid;
    end
    check({tag, "_lat"}, 32'(n), 32'd9);
    check({tag, "_id"}, 32'(issue.rsp_id), 32'(r));
    check({tag, "_res1"}, issue.rsp_data1, exp1);
    check({tag, "_hold"}, alu_data1, d1);
  endtask

  int          gq [8];
  int          rq [8];
  logic [31:0] rd [8];
  int          exp_g [4] = '{0, 1, 0, 1};
  logic [31:0] exp_d [4] = '{32'd2, 32'd30, 32'd2, 32'd30};

  initial begin
    int ng, nr, t0, n, r0;
    bit bad, done, seen;

    issue.req_valid  = '0;
    issue.req_type   = '0;
    issue.req_data1  = '0;
    issue.req_data2  = '0;
    issue.req_data3  = '0;
    issue.req_data4  = '0;
    issue.req_srcdst = '0;
    repeat (3) step();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_trig", 32'(alu_trigger), 32'd0);
    check("rst_go", 32'(alu_go), 32'd0);
    check("rst_rsp", 32'(issue.rsp_valid), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    check("rst_d1", alu_data1, 32'd0);
    reset   = 1'b0;
    alu_rst = 1'b0;

    // Single op, first_op launch with ALU ready still low
    t0 = tog_cnt;
    do_op(0, 32'd5, 32'd3, TYPE_DP, 32'h0, 32'd8, "t1");
    check("t1_trig", 32'(alu_trigger), 32'd1);
    check("t1_tog", 32'(tog_cnt - t0), 32'd1);

    // Result passthrough
    cpsr_cfg = 32'h4000_0000;
    w_cfg    = 1'b0;
    m_cfg    = 1'b1;
    do_op(0, 32'd7, 32'd2, TYPE_LDST, 32'h10, 32'd9, "t6");
    check("t6_type", 32'(alu_type), 32'd2);
    check("t6_cpsr", issue.rsp_cpsr, 32'h4000_0000);
    check("t6_w", 32'(issue.rsp_w), 32'd0);
    check("t6_m", 32'(issue.rsp_m), 32'd1);
    check("t6_sd", issue.rsp_srcdst, 32'h10);
    check("t6_res2", issue.rsp_data2, 32'd5);

    // Contention: both valid, four ops
    do_reset();
    set_req(0, 32'd1, 32'd1, TYPE_DP, 32'h0);
    set_req(1, 32'd10, 32'd20, TYPE_BR, 32'h0);
    t0 = tog_cnt;
    ng = 0;
    nr = 0;
    issue.req_valid = 2'b11;
    #1;
    for (int c = 0; c < 80 && nr < 4; c++) begin
      if (c > 0) step();
      if (ng == 4) issue.req_valid = '0;
      #1;
      if (issue.req_ready != '0 && ng < 8) begin
        gq[ng] = (issue.req_ready == 2'b10) ? 1 : 0;
        ng++;
      end
      if (issue.rsp_valid && nr < 8) begin
        rq[nr] = int'(issue.rsp_id);
        rd[nr] = issue.rsp_data1;
        nr++;
      end
    end
    check("t2_ngrant", 32'(ng), 32'd4);
    check("t2_nrsp", 32'(nr), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("t2_grant", 32'(gq[k]), 32'(exp_g[k]));
      check("t2_rspid", 32'(rq[k]), 32'(exp_g[k]));
      check("t2_res1", rd[k], exp_d[k]);
    end
    check("t2_tog", 32'(tog_cnt - t0), 32'd4);

    // Busy hold: req1 raised mid-op must wait for IDLE
    step();
    set_req(0, 32'd100, 32'd1, TYPE_DP, 32'h0);
    issue.req_valid[0] = 1'b1;
    #1;
    check("t3_grant0", 32'(issue.req_ready), 32'd1);
    n = 0;
    bad = 1'b0;
    done = 1'b0;
    while (!done && n < 40) begin
      step();
      n++;
      if (n == 1) begin
        issue.req_valid[0] = 1'b0;
        issue.req_data1[31:0] = 32'h5555_aaaa;
      end
      if (n == 5) begin
        set_req(1, 32'd40, 32'd2, TYPE_DP, 32'h0);
        issue.req_valid[1] = 1'b1;
      end
      #1;
      if (busy) begin
        if (issue.req_ready != '0) bad = 1'b1;
        if (alu_data1 != 32'd100) bad = 1'b1;
      end else begin
        done = 1'b1;
      end
    end
    check("t3_hold", 32'(bad), 32'd0);
    check("t3_n", 32'(n), 32'd9);
    check("t3_res0", issue.rsp_data1, 32'd101);
    check("t3_grant1", 32'(issue.req_ready), 32'd2);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (n == 1) issue.req_valid[1] = 1'b0;
      seen = issue.rsp_valid;
    end
    check("t3_id1", 32'(issue.rsp_id), 32'd1);
    check("t3_res1", issue.rsp_data1, 32'd42);

    // Reset mid-op (in WAIT_HI)
    step();
    set_req(0, 32'd3, 32'd4, TYPE_DP, 32'h0);
    issue.req_valid[0] = 1'b1;
    #1;
    check("t4_grant", 32'(issue.req_ready), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) issue.req_valid[0] = 1'b0;
    end
    check("t4_busy_pre", 32'(busy), 32'd1);
    check("t4_trig_pre", 32'(alu_trigger), 32'd1);
    r0 = rsp_cnt;
    reset   = 1'b1;
    alu_rst = 1'b1;
    #1;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_trig", 32'(alu_trigger), 32'd0);
    check("t4_go", 32'(alu_go), 32'd0);
    check("t4_d1", alu_data1, 32'd0);
    check("t4_rsp", 32'(issue.rsp_valid), 32'd0);
    step();
    step();
    reset   = 1'b0;
    alu_rst = 1'b0;
    repeat (6) step();
    check("t4_norsp", 32'(rsp_cnt - r0), 32'd0);
    do_op(0, 32'd20, 32'd22, TYPE_DP, 32'h0, 32'd42, "t4b");

`ifdef ALU_ARB_TIMEOUT_EN
    // Watchdog: ALU never raises ready
    hang = 1'b1;
    r0 = rsp_cnt;
    step();
    set_req(0, 32'd1, 32'd2, TYPE_DP, 32'h0);
    issue.req_valid[0] = 1'b1;
    #1;
    check("t5_grant", 32'(issue.req_ready), 32'd1);
    n = 0;
    while (!error && n < TO + 10) begin
      step();
      n++;
      if (n == 1) issue.req_valid[0] = 1'b0;
    end
    check("t5_err", 32'(error), 32'd1);
    check("t5_n", 32'(n), 32'(TO + 1));
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_go", 32'(alu_go), 32'd0);
    check("t5_norsp", 32'(rsp_cnt - r0), 32'd0);
    hang = 1'b0;
    do_op(0, 32'd6, 32'd6, TYPE_DP, 32'h0, 32'd12, "t5b");
    check("t5_sticky", 32'(error), 32'd1);
`else
    check("t5_err_off", 32'(error), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Synchronous front end that shares the single asynchronous ALU between NREQ requesters (decoder issue slots).
- Round-robin arbitration picks one request. The block registers its payload, drives the ALU's toggle-trigger / ready handshake and waits for completion through a synchronizer.
- ALU results (data, CPSR, w, m, srcDst) are returned to the requester as a one-cycle tagged response.
- Sits between the decoder issue logic and the ALU; memory-side consumers read the response bus.

Parameters:
- NREQ, 2, number of requesters (2..4).
- SYNC_STAGES, 2, flop stages on alu_ready_i (>=2).
- TIMEOUT, 255, watchdog limit in clk cycles (used only with ALU_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  one-hot accept pulse
- req_type  in  NREQ*4  per-requester instruction type
- req_data1, req_data2, req_data3, req_data4  in  NREQ*32 each  operands / instruction word
- req_srcdst  in  NREQ*32  per-requester srcDst
- alu_data1, alu_data2, alu_data3, alu_data4  out  32 each  registered payload to the ALU
- alu_type  out  4  registered type
- alu_srcdst  out  32  registered srcDst
- alu_trigger  out  1  toggles once per operation (ALU triggerIn)
- alu_go  out  1  payload-valid level (ALU readyIn)
- alu_ready_i  in  1  ALU readyOut, asynchronous
- alu_res1, alu_res2, alu_cpsr, alu_srcdst_i  in  32 each  ALU result outputs
- alu_w, alu_m  in  1 each  ALU write / memory flags
- rsp_valid  out  1  one-cycle completion pulse
- rsp_id  out  clog2(NREQ)  granted requester index
- rsp_data1, rsp_data2, rsp_cpsr, rsp_srcdst  out  32 each  captured results
- rsp_w, rsp_m  out  1 each  captured flags
- busy  out  1  high in any state other than IDLE
- error  out  1  sticky watchdog flag

Behaviour:
- Reset values:
  - All outputs 0; alu_trigger = 0.
  - State IDLE, round-robin pointer = NREQ-1, first_op = 1, sync chain cleared.
- rdy_s is alu_ready_i after SYNC_STAGES flops.

States:
- IDLE:
  - Launch is allowed when any req_valid is set AND (rdy_s OR first_op).
  - Grant: first valid index after the pointer, wrapping modulo NREQ.
  - In that cycle: req_ready[g] = 1, payload latched into alu_* registers, pointer <= g, state -> LAUNCH.
  - Launch not allowed: req_ready = 0.
- LAUNCH (1 cycle): alu_trigger <= ~alu_trigger, alu_go <= 1, state -> WAIT_LO.
- WAIT_LO: stay until rdy_s = 0, then -> WAIT_HI. An ALU ready that is already low passes on the first cycle.
- WAIT_HI: stay until rdy_s = 1, then -> CAPTURE.
- CAPTURE (1 cycle):
  - rsp_* <= alu_* inputs, rsp_id <= g, rsp_valid = 1.
  - alu_go <= 0, first_op <= 0, state -> IDLE.

Timing and handshake rules:
- rsp_valid is a single-cycle pulse. It is not back-pressured; the consumer must accept it.
- alu_* payload is held stable from LAUNCH through CAPTURE.
- req_ready asserts at most one bit, and only in IDLE.
- Minimum accept-to-rsp_valid latency: 4 + SYNC_STAGES cycles.
- A request arriving during busy waits. req_valid must stay high until its req_ready pulse.

Round-robin examples, NREQ = 2:
- Both valid, pointer = 1 -> grant 0.
- Next cycle with both still valid -> grant 1.

Reset:
- reset mid-operation aborts to IDLE immediately; the in-flight result is discarded and no rsp_valid is issued.
- Asserting it mid-operation is legal only together with the ALU's own reset, because the ALU must be re-armed.
- alu_trigger returns to 0. The ALU detects both edges, so the next LAUNCH toggle is always seen.

Optional Feature:
- Macro: ALU_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on LAUNCH and counts in WAIT_LO / WAIT_HI.
  - When it reaches TIMEOUT: error <= 1 (sticky until reset), alu_go <= 0, state -> IDLE, no rsp_valid.
  - first_op <= 1, so a hung ALU does not deadlock the arbiter.
- Not defined: no counter; the WAIT states wait indefinitely; error is tied to 0.

Decomposition:
- Package alu_arb_pkg:
  - State enum IDLE / LAUNCH / WAIT_LO / WAIT_HI / CAPTURE.
  - Type constants TYPE_DP = 4'b0000, TYPE_BR = 4'b0001, TYPE_LDST = 4'b0010.
  - DATA_W = 32.
  - Default TIMEOUT.
- Sub-module alu_ready_sync: SYNC_STAGES flop chain with async active-high reset, output rdy_s.

Test Plan:
1. Single op: req0 valid, type 0, data1 = 5, data2 = 3, ALU model returns res1 = 8 after 3 clk -> req_ready = 01, one alu_trigger toggle, rsp_valid pulse with rsp_id = 0, rsp_data1 = 8, at accept + 4 + SYNC_STAGES + 3 cycles.
2. Contention: req0 and req1 valid continuously for 4 ops after reset -> grant order 0, 1, 0, 1; exactly 4 trigger toggles; rsp_id matches each grant.
3. Busy hold: req1 raised during WAIT_HI of a req0 op -> req_ready stays 00 until IDLE; alu_data* is unchanged over the whole op.
4. Reset mid-op: reset asserted in WAIT_HI -> all outputs 0 next cycle, no rsp_valid. After release, a new req0 completes normally with first_op semantics.
5. Watchdog (ALU_ARB_TIMEOUT_EN, TIMEOUT = 20): ALU never raises ready -> error = 1 at LAUNCH + 20, state IDLE, no rsp_valid. The next request still launches.
6. Result passthrough: ALU returns cpsr = 32'h4000_0000, w = 0, m = 1, srcdst = 32'h10 -> rsp_cpsr, rsp_w, rsp_m and rsp_srcdst carry the same values in the CAPTURE cycle.
